fifo_wr_arb: RTL and testbench

//  Round-robin arbiter sharing one FIFO write port among NREQ packet sources.

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arb_rr_pick.sv | 35 +++
 rtl/fifo_wr_arb.sv | 105 ++++++++++
 tb/tb_fifo_wr_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter state encoding and a constant-width helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Smallest width able to index 'value' distinct items (minimum 1).
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        gnt_idx = '0;
        any     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            idx = sum[IW-1:0];
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ packet sources.
// A grant is held until the packet's last beat or MAX_BURST beats, whichever comes first.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          src_valid,
    input  logic [NREQ-1:0]          src_last,
    input  logic [NREQ*DSIZE-1:0]    src_data,
    output logic [NREQ-1:0]          src_ready,
    input  logic                     fifo_wfull,
    output logic                     fifo_winc,
    output logic [DSIZE-1:0]         fifo_wdata,
    output logic [clog2(NREQ)-1:0]   gnt_id,
    output logic                     busy
);

    localparam int IW = clog2(NREQ);
    localparam int CW = clog2(MAX_BURST + 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   gnt_q, gnt_nxt;
    logic [IW-1:0]   rr_ptr, rr_nxt;
    logic [CW-1:0]   beat_cnt, cnt_nxt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            beat;
    logic            grant_end;
    logic [DSIZE-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = src_data[i*DSIZE +: DSIZE];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (src_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Write-side datapath: only the granted source is ever offered ready.
    always_comb begin
        beat       = (state == BUSY) && src_valid[gnt_q] && !fifo_wfull;
        grant_end  = beat && (src_last[gnt_q] || (beat_cnt == CW'(MAX_BURST - 1)));
        src_ready  = '0;
        if (state == BUSY && !fifo_wfull) begin
            src_ready[gnt_q] = 1'b1;
        end
        fifo_winc  = beat;
        fifo_wdata = data_arr[gnt_q];
        busy       = (state == BUSY);
        gnt_id     = gnt_q;
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        rr_nxt    = rr_ptr;
        cnt_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_nxt   = pick_idx;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Release hands priority to the source after the one just served.
                if (grant_end) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    rr_nxt    = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
                end else if (beat) begin
                    cnt_nxt = beat_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            gnt_q    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt_q    <= gnt_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level owner/turn model.
module tb_fifo_wr_arb;

    localparam int NREQ      = 4;
    localparam int DSIZE     = 8;
    localparam int MAX_BURST = 16;
    localparam int IW        = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       src_valid;
    logic [NREQ-1:0]       src_last;
    logic [NREQ*DSIZE-1:0] src_data;
    logic [NREQ-1:0]       src_ready;
    logic                  fifo_wfull;
    logic                  fifo_winc;
    logic [DSIZE-1:0]      fifo_wdata;
    logic [IW-1:0]         gnt_id;
    logic                  busy;

    fifo_wr_arb #(
        .NREQ      (NREQ),
        .DSIZE     (DSIZE),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_last   (src_last),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .fifo_wfull (fifo_wfull),
        .fifo_winc  (fifo_winc),
        .fifo_wdata (fifo_wdata),
        .gnt_id     (gnt_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Source traffic configuration and state.
    int en_pkts   [NREQ];   // packets still to send, -1 = endless
    int len_min   [NREQ];
    int len_max   [NREQ];
    int valid_pct [NREQ];
    int pkt_left  [NREQ];
    int seq       [NREQ];
    int wfull_pct;
    int full_from, full_to;
    int gap_src, gap_from, gap_to;
    int cyc;

    // Reference model: who owns the port, whose turn is next, beats in this grant.
    int m_owner = -1;
    int m_turn  = 0;
    int m_beats = 0;

    int wr_owner[$];
    int wr_cyc[$];
    int wr_data[$];

    task automatic configure_idle();
        for (int i = 0; i < NREQ; i++) begin
            en_pkts[i]   = 0;
            len_min[i]   = 1;
            len_max[i]   = 1;
            valid_pct[i] = 100;
            pkt_left[i]  = 0;
        end
        wfull_pct = 0;
        full_from = -1;
        full_to   = -1;
        gap_src   = -1;
        gap_from  = -1;
        gap_to    = -1;
    endtask

    task automatic clear_log();
        wr_owner.delete();
        wr_cyc.delete();
        wr_data.delete();
        cyc = 0;
    endtask

    task automatic drive_cycle(input logic r);
        logic [NREQ-1:0] exp_ready;
        logic            exp_winc;
        logic            v;
        int              exp_data;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < NREQ; i++) begin
            if (pkt_left[i] == 0 && en_pkts[i] != 0) begin
                pkt_left[i] = int'($urandom_range(len_max[i], len_min[i]));
            end
            v = (pkt_left[i] > 0) && (int'($urandom_range(99)) < valid_pct[i]);
            if (i == gap_src && cyc >= gap_from && cyc < gap_to) v = 1'b0;
            src_valid[i] = v;
            src_last[i]  = (pkt_left[i] == 1);
            src_data[i*DSIZE +: DSIZE] = DSIZE'(i * 64 + seq[i] % 64);
        end
        fifo_wfull = (cyc >= full_from && cyc < full_to) || (int'($urandom_range(99)) < wfull_pct);

        exp_ready = '0;
        exp_winc  = 1'b0;
        exp_data  = 0;
        if (m_owner >= 0) begin
            if (!fifo_wfull) exp_ready[m_owner] = 1'b1;
            exp_winc = src_valid[m_owner] && !fifo_wfull;
            exp_data = m_owner * 64 + seq[m_owner] % 64;
        end

        #1;
        check("busy", busy, m_owner >= 0);
        check("src_ready", src_ready, exp_ready);
        check("fifo_winc", fifo_winc, exp_winc);
        if (exp_winc) check("fifo_wdata", fifo_wdata, exp_data);
        if (m_owner >= 0) check("gnt_id", gnt_id, m_owner);
        if (fifo_winc) begin
            wr_owner.push_back(int'(gnt_id));
            wr_cyc.push_back(cyc);
            wr_data.push_back(int'(fifo_wdata));
        end

        @(posedge clk);
        if (exp_winc) begin
            seq[m_owner]++;
            pkt_left[m_owner]--;
            if (pkt_left[m_owner] == 0 && en_pkts[m_owner] > 0) en_pkts[m_owner]--;
        end
        if (r) begin
            m_owner = -1;
            m_turn  = 0;
            m_beats = 0;
            for (int i = 0; i < NREQ; i++) pkt_left[i] = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_owner < 0 && src_valid[(m_turn + k) % NREQ]) m_owner = (m_turn + k) % NREQ;
            end
        end else if (exp_winc) begin
            m_beats++;
            if (src_last[m_owner] || m_beats == MAX_BURST) begin
                m_turn  = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_beats = 0;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0);
    endtask

    task automatic do_reset();
        configure_idle();
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_winc", fifo_winc, 1'b0);
        check("rst_ready", src_ready, 0);
        clear_log();
    endtask

    int run_own[$];
    int run_len[$];
    int exp_runs[5] = '{16, 101, 16, 101, 8};  // owner*100 + beats

    initial begin
        rst        = 1'b1;
        src_valid  = '0;
        src_last   = '0;
        src_data   = '0;
        fifo_wfull = 1'b0;
        for (int i = 0; i < NREQ; i++) seq[i] = 0;
        configure_idle();
        clear_log();

        // Single 3-beat packet from source 2.
        do_reset();
        en_pkts[2] = 1;
        len_min[2] = 3;
        len_max[2] = 3;
        run(8);
        check("single_count", wr_owner.size(), 3);
        check("single_first_cyc", wr_cyc[0], 1);
        check("single_last_cyc", wr_cyc[2], 3);
        for (int k = 0; k < 3; k++) begin
            check("single_owner", wr_owner[k], 2);
            check("single_data", wr_data[k], 2 * 64 + k);
        end

        // Four sources with endless 1-beat packets: strict rotation.
        do_reset();
        for (int i = 0; i < NREQ; i++) en_pkts[i] = -1;
        run(40);
        check("rotate_count", wr_owner.size(), 20);
        for (int k = 0; k < 16; k++) check("rotate_owner", wr_owner[k], k % NREQ);

        // 40-beat packet cut into MAX_BURST slices, interleaved with source 1.
        do_reset();
        en_pkts[0] = 1;
        len_min[0] = 40;
        len_max[0] = 40;
        en_pkts[1] = -1;
        run(60);
        run_own.delete();
        run_len.delete();
        foreach (wr_owner[k]) begin
            if (run_own.size() != 0 && run_own[$] == wr_owner[k]) run_len[$] = run_len[$] + 1;
            else begin
                run_own.push_back(wr_owner[k]);
                run_len.push_back(1);
            end
        end
        for (int k = 0; k < 5; k++) check("burst_run", run_own[k] * 100 + run_len[k], exp_runs[k]);

        // FIFO full for 5 cycles in the middle of a 10-beat packet.
        do_reset();
        en_pkts[1] = 1;
        len_min[1] = 10;
        len_max[1] = 10;
        full_from  = 4;
        full_to    = 9;
        run(20);
        check("full_count", wr_owner.size(), 10);
        check("full_resume_cyc", wr_cyc[3], 9);

        // Granted source goes quiet for 3 cycles while source 3 waits.
        do_reset();
        en_pkts[0] = 1;
        len_min[0] = 6;
        len_max[0] = 6;
        en_pkts[3] = -1;
        gap_src    = 0;
        gap_from   = 3;
        gap_to     = 6;
        run(20);
        for (int k = 0; k < 6; k++) check("gap_owner", wr_owner[k], 0);
        check("gap_resume_cyc", wr_cyc[2], 6);
        check("gap_next_owner", wr_owner[6], 3);
        check("gap_next_cyc", wr_cyc[6], 11);

        // Reset in the middle of a packet.
        do_reset();
        en_pkts[1] = 1;
        len_min[1] = 10;
        len_max[1] = 10;
        run(5);
        check("pre_rst_busy", busy, 1'b1);
        drive_cycle(1'b1);
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", src_ready, 0);
        check("mid_rst_winc", fifo_winc, 1'b0);
        for (int i = 0; i < NREQ; i++) en_pkts[i] = -1;
        clear_log();
        run(6);
        check("post_rst_owner", wr_owner[0], 0);

        // Randomized traffic with back-pressure and occasional reset.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            en_pkts[i]   = -1;
            len_min[i]   = 1;
            len_max[i]   = 40;
            valid_pct[i] = 75;
        end
        wfull_pct = 20;
        for (int i = 0; i < 1500; i++) drive_cycle($urandom_range(199) == 0);
        check("random_progress", wr_owner.size() > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
